spi_frame_rx: RTL and testbench

SPI_FRAME_RX -- requirements
Module: spi_frame_rx

---
 rtl/spi_frame_rx_pkg.sv | 16 +
 rtl/spi_rx_sync.sv | 39 +++
 rtl/spi_frame_rx.sv | 173 +++++++++++++++++
 tb/tb_spi_frame_rx.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_rx_pkg.sv
`default_nettype none
// spi_frame_rx_pkg: frame constants and receiver state encoding shared by
// the SPI frame transmit and receive sides.
package spi_frame_rx_pkg;

  localparam int          TOTAL_FRAME_DEF     = 255;
  localparam logic [31:0] LAST_FRAME_DATA_DEF = 32'h0000_1234;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_LAST = 2'd2
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_rx_sync.sv
`default_nettype none
// spi_rx_sync: brings the asynchronous SPI pins into the clk domain and
// reports sck rising and ss falling/rising edges as single-cycle strobes.
module spi_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic sdi_i,
  input  logic ss_i,
  output logic sck_rise_o,
  output logic ss_fall_o,
  output logic ss_rise_o,
  output logic sdi_s_o
);

  // Bits [1:0] form the two-flop synchronizer; bit [2] is the edge-detect history.
  logic [2:0] sck_q;
  logic [2:0] ss_q;
  logic [1:0] sdi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= 3'b000;
      ss_q  <= 3'b111;
      sdi_q <= 2'b00;
    end else begin
      sck_q <= {sck_q[1:0], sck_i};
      ss_q  <= {ss_q[1:0], ss_i};
      sdi_q <= {sdi_q[0], sdi_i};
    end
  end

  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign ss_fall_o  = ~ss_q[1] & ss_q[2];
  assign ss_rise_o  = ss_q[1] & ~ss_q[2];
  assign sdi_s_o    = sdi_q[1];

endmodule
`default_nettype wire

// File: rtl/spi_frame_rx.sv
`default_nettype none
// spi_frame_rx: SPI slave that collects a frame of 32-bit words, checks the
// trailing end-of-frame marker and hands data words out through a show-ahead FIFO.
module spi_frame_rx
  import spi_frame_rx_pkg::*;
#(
  parameter int          TOTAL_FRAME     = TOTAL_FRAME_DEF,
  parameter logic [31:0] LAST_FRAME_DATA = LAST_FRAME_DATA_DEF,
  parameter int          FIFO_AW         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        sdi,
  input  logic        ss,
  output logic [31:0] data,
  output logic        valid,
  input  logic        ready,
  output logic [8:0]  word_cnt,
  output logic        frame_done,
  output logic        frame_err,
  output logic        overflow
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [8:0]       TOTAL_W = 9'(TOTAL_FRAME);
  localparam logic [FIFO_AW:0] DEPTH_W = (FIFO_AW + 1)'(DEPTH);

  logic sck_rise, ss_fall, ss_rise, sdi_s;

  spi_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .sck_i      (sck),
    .sdi_i      (sdi),
    .ss_i       (ss),
    .sck_rise_o (sck_rise),
    .ss_fall_o  (ss_fall),
    .ss_rise_o  (ss_rise),
    .sdi_s_o    (sdi_s)
  );

  rx_state_e   state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [8:0]  word_cnt_q, word_cnt_d;
  logic        push_q, push_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] word_new;
  logic        bit_evt, word_evt;

  assign word_new = {shift_q[30:0], sdi_s};
  assign bit_evt  = sck_rise && (state_q != ST_IDLE);
  assign word_evt = bit_evt && (bit_cnt_q == 5'd31);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 5'd0;
      shift_q    <= 32'd0;
      word_cnt_q <= 9'd0;
      push_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      push_q     <= push_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    push_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (bit_evt) begin
      shift_d   = word_new;
      bit_cnt_d = bit_cnt_q + 5'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d    = ST_DATA;
          word_cnt_d = 9'd0;
          bit_cnt_d  = 5'd0;
        end
      end
      ST_DATA: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (word_evt) begin
          // The word itself sits in shift_q next cycle and is pushed from there.
          push_d     = 1'b1;
          word_cnt_d = word_cnt_q + 9'd1;
          if (word_cnt_q + 9'd1 == TOTAL_W) begin
            state_d = ST_LAST;
          end
        end
      end
      ST_LAST: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (word_evt) begin
          state_d = ST_IDLE;
          done_d  = (word_new == LAST_FRAME_DATA);
          err_d   = (word_new != LAST_FRAME_DATA);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [31:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               ovf_q;
  logic               full, pop, wr_en;

  assign full  = (level_q == DEPTH_W);
  assign valid = (level_q != '0);
  assign pop   = valid & ready;
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = push_q & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (push_q && !wr_en) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign data       = valid ? mem_q[rd_ptr_q] : 32'd0;
  assign word_cnt   = word_cnt_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
`default_nettype none
// tb_spi_frame_rx: drives SPI frames into spi_frame_rx and checks the output
// stream and status pulses against expectations derived from the frame rules.
module tb_spi_frame_rx;
  import spi_frame_rx_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        sck   = 1'b0;
  logic        sdi   = 1'b0;
  logic        ss    = 1'b1;
  logic        ready = 1'b0;
  logic [31:0] data;
  logic        valid;
  logic [8:0]  word_cnt;
  logic        frame_done, frame_err, overflow;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_err  = 0;
  logic [31:0] got_q [$];

  spi_frame_rx dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .sdi        (sdi),
    .ss         (ss),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .word_cnt   (word_cnt),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Observed stream: every accepted word and every status pulse cycle.
  always @(negedge clk) begin
    if (valid && ready) got_q.push_back(data);
    if (frame_done) n_done++;
    if (frame_err) n_err++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    tick(2);
    sck = 1'b1;
    tick(2);
    sck = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i >= 32 - n; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
  endtask

  task automatic start_frame();
    ss = 1'b0;
    tick(3);
  endtask

  task automatic end_frame();
    tick(2);
    ss = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total++;
    if (valid !== 1'b0 || data !== 32'd0) begin
      bad++; $display("FAIL reset_out: valid=%b data=%h, need 0 and 0", valid, data);
    end
    total++;
    if ({frame_done, frame_err, overflow} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: done/err/ovf=%b, need 000", {frame_done, frame_err, overflow});
    end
    total++;
    if (word_cnt !== 9'd0) begin
      bad++; $display("FAIL reset_cnt: word_cnt=%0d, need 0", word_cnt);
    end
    rst = 1'b0;
    tick(6);
    total++;
    if (valid !== 1'b0 || n_err != 0 || n_done != 0) begin
      bad++; $display("FAIL idle_quiet: valid=%b err=%0d done=%0d, need 0/0/0", valid, n_err, n_done);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] w [5];
    int base;
    int mism;
    base = got_q.size();
    for (int i = 0; i < 5; i++) w[i] = $urandom();
    ready = 1'b0;
    start_frame();
    for (int i = 0; i < 4; i++) send_word(w[i]);
    tick(4);
    total++;
    if (valid !== 1'b1 || data !== w[0]) begin
      bad++; $display("FAIL full_head: valid=%b data=%h, need 1 and %h", valid, data, w[0]);
    end
    // Last bit of the fifth word: pulse ready so the pop meets the push.
    send_bits(w[4], 31);
    sdi = w[4][0];
    tick(2);
    sck = 1'b1;
    tick(2);
    sck = 1'b0;
    tick(1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(6);
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL full_pop_ovf: overflow=%b, need 0", overflow);
    end
    total++;
    if (valid !== 1'b1 || data !== w[1]) begin
      bad++; $display("FAIL full_pop_head: valid=%b data=%h, need 1 and %h", valid, data, w[1]);
    end
    ready = 1'b1;
    tick(12);
    total++;
    if (got_q.size() - base != 5) begin
      bad++; $display("FAIL full_pop_count: got %0d words, need 5", got_q.size() - base);
    end
    total++;
    mism = 0;
    for (int i = 0; i < 5 && base + i < got_q.size(); i++)
      if (got_q[base + i] !== w[i]) mism++;
    if (mism != 0) begin
      bad++; $display("FAIL full_pop_data: %0d words differ from expected order", mism);
    end
    end_frame();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_q [$];
    int base;
    int mism;
    base = got_q.size();
    for (int i = 0; i < 6; i++)
      if (i < FIFO_DEPTH) exp_q.push_back(32'h0000_00A0 + 32'(i));
    ready = 1'b0;
    start_frame();
    for (int i = 0; i < 6; i++) send_word(32'h0000_00A0 + 32'(i));
    tick(4);
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_flag: overflow=%b, need 1", overflow);
    end
    total++;
    if (word_cnt !== 9'd6) begin
      bad++; $display("FAIL ovf_cnt: word_cnt=%0d, need 6", word_cnt);
    end
    total++;
    if (valid !== 1'b1 || data !== 32'h0000_00A0) begin
      bad++; $display("FAIL ovf_head: valid=%b data=%h, need 1 and a0", valid, data);
    end
    ready = 1'b1;
    tick(10);
    total++;
    mism = (got_q.size() - base != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
      if (got_q[base + i] !== exp_q[i]) mism++;
    if (mism != 0) begin
      bad++; $display("FAIL ovf_drain: got %0d words (%0d errors), need %0d in order", got_q.size() - base, mism, exp_q.size());
    end
    end_frame();
  endtask

  task automatic test_abort();
    logic [31:0] exp_q [$];
    logic [31:0] w;
    int base;
    int e0;
    int mism;
    base = got_q.size();
    e0 = n_err;
    ready = 1'b1;
    start_frame();
    for (int i = 0; i < 10; i++) begin
      w = $urandom();
      exp_q.push_back(w);
      send_word(w);
    end
    send_bits($urandom(), 17);
    ss = 1'b1;
    tick(8);
    total++;
    if (n_err != e0 + 1) begin
      bad++; $display("FAIL abort_err: frame_err pulses=%0d, need 1", n_err - e0);
    end
    total++;
    mism = (got_q.size() - base != 10) ? 1 : 0;
    for (int i = 0; i < 10 && base + i < got_q.size(); i++)
      if (got_q[base + i] !== exp_q[i]) mism++;
    if (mism != 0) begin
      bad++; $display("FAIL abort_words: got %0d words (%0d errors), need 10 in order", got_q.size() - base, mism);
    end
    send_bits($urandom(), 20);
    tick(4);
    total++;
    if (word_cnt !== 9'd10 || valid !== 1'b0) begin
      bad++; $display("FAIL idle_ignore: word_cnt=%0d valid=%b, need 10 and 0", word_cnt, valid);
    end
    start_frame();
    total++;
    if (word_cnt !== 9'd0) begin
      bad++; $display("FAIL restart_cnt: word_cnt=%0d, need 0", word_cnt);
    end
    w = $urandom();
    send_word(w);
    tick(6);
    total++;
    if (got_q.size() != base + 11 || got_q[got_q.size() - 1] !== w || word_cnt !== 9'd1) begin
      bad++; $display("FAIL restart_word: words=%0d cnt=%0d, need %0d words ending %h, cnt 1", got_q.size() - base, word_cnt, 11, w);
    end
    end_frame();
    total++;
    if (n_err != e0 + 2) begin
      bad++; $display("FAIL restart_abort: frame_err pulses=%0d, need 2", n_err - e0);
    end
  endtask

  task automatic test_bad_marker();
    logic [31:0] exp_q [$];
    logic [31:0] w;
    int base;
    int e0;
    int d0;
    int mism;
    base = got_q.size();
    e0 = n_err;
    d0 = n_done;
    ready = 1'b1;
    start_frame();
    for (int i = 0; i < TOTAL_FRAME_DEF; i++) begin
      w = $urandom();
      exp_q.push_back(w);
      send_word(w);
    end
    send_word(32'hDEAD_BEEF);
    tick(6);
    end_frame();
    total++;
    if (n_err != e0 + 1 || n_done != d0) begin
      bad++; $display("FAIL bad_marker: err=%0d done=%0d, need 1 and 0", n_err - e0, n_done - d0);
    end
    total++;
    if (word_cnt !== 9'd255) begin
      bad++; $display("FAIL bad_cnt: word_cnt=%0d, need 255", word_cnt);
    end
    total++;
    mism = (got_q.size() - base != TOTAL_FRAME_DEF) ? 1 : 0;
    for (int i = 0; i < TOTAL_FRAME_DEF && base + i < got_q.size(); i++)
      if (got_q[base + i] !== exp_q[i]) mism++;
    if (mism != 0) begin
      bad++; $display("FAIL bad_words: got %0d words (%0d errors), need 255 in order", got_q.size() - base, mism);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] exp_q [$];
    logic [31:0] w;
    int base;
    int e0;
    int mism;
    base = got_q.size();
    ready = 1'b1;
    start_frame();
    for (int i = 0; i < 100; i++) begin
      w = $urandom();
      exp_q.push_back(w);
      send_word(w);
    end
    send_bits($urandom(), 10);
    e0 = n_err;
    rst = 1'b1;
    ss  = 1'b1;
    tick(1);
    rst = 1'b0;
    total++;
    if (valid !== 1'b0 || data !== 32'd0 || word_cnt !== 9'd0) begin
      bad++; $display("FAIL rst_mid_out: valid=%b data=%h cnt=%0d, need all 0", valid, data, word_cnt);
    end
    total++;
    if ({frame_done, frame_err, overflow} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_flags: done/err/ovf=%b, need 000", {frame_done, frame_err, overflow});
    end
    tick(10);
    total++;
    if (n_err != e0) begin
      bad++; $display("FAIL rst_mid_err: frame_err pulses=%0d, need 0", n_err - e0);
    end
    total++;
    mism = (got_q.size() - base != 100) ? 1 : 0;
    for (int i = 0; i < 100 && base + i < got_q.size(); i++)
      if (got_q[base + i] !== exp_q[i]) mism++;
    if (mism != 0) begin
      bad++; $display("FAIL rst_mid_words: got %0d words (%0d errors), need 100", got_q.size() - base, mism);
    end
  endtask

  task automatic test_full_frame();
    int base;
    int e0;
    int d0;
    int mism;
    base = got_q.size();
    e0 = n_err;
    d0 = n_done;
    ready = 1'b1;
    start_frame();
    for (int i = 0; i < TOTAL_FRAME_DEF; i++) send_word(32'(i));
    tick(6);
    total++;
    if (word_cnt !== 9'd255) begin
      bad++; $display("FAIL frame_cnt: word_cnt=%0d, need 255", word_cnt);
    end
    send_word(LAST_FRAME_DATA_DEF);
    tick(6);
    total++;
    if (n_done != d0 + 1 || n_err != e0) begin
      bad++; $display("FAIL frame_done: done=%0d err=%0d, need 1 and 0", n_done - d0, n_err - e0);
    end
    end_frame();
    total++;
    mism = (got_q.size() - base != TOTAL_FRAME_DEF) ? 1 : 0;
    for (int i = 0; i < TOTAL_FRAME_DEF && base + i < got_q.size(); i++)
      if (got_q[base + i] !== 32'(i)) mism++;
    if (mism != 0) begin
      bad++; $display("FAIL frame_words: got %0d words (%0d errors), need 0..254", got_q.size() - base, mism);
    end
    total++;
    if (n_err != e0 || valid !== 1'b0) begin
      bad++; $display("FAIL frame_tail: err=%0d valid=%b, need 0 and 0", n_err - e0, valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_pop();
    test_overflow();
    test_abort();
    test_bad_marker();
    test_reset_midframe();
    test_full_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
